axi_cdma_desc_split: RTL

Descriptor segmenter placed directly upstream of `axi_cdma`. It accepts one copy request of arbitrary length and issues a sequence of CDMA descriptors, each no longer than `SEG_SIZE` bytes and never crossing a `SEG_SIZE` boundary in the write address space. It counts the per-chunk completions returned by the CDMA and emits a single completion carrying the original request tag once every chunk has finished. It also bounds the number of chunks in flight.

---
 rtl/axi_cdma_desc_split.sv | 125 ++++++++++++
 1 files changed

// File: rtl/axi_cdma_desc_split.sv
// Splits one copy request into SEG_SIZE-bounded CDMA descriptors and merges their completions.
// Optional tag-order/underflow checker enabled by defining CDMA_SPLIT_ORDER_CHECK_EN.
module axi_cdma_desc_split #(
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int TAG_WIDTH       = 8,
  parameter int SEG_SIZE        = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axis_req_read_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axis_req_write_addr,
  input  logic [LEN_WIDTH-1:0]      s_axis_req_len,
  input  logic [TAG_WIDTH-1:0]      s_axis_req_tag,
  input  logic                      s_axis_req_valid,
  output logic                      s_axis_req_ready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_read_addr,
  output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_write_addr,
  output logic [LEN_WIDTH-1:0]      m_axis_desc_len,
  output logic [TAG_WIDTH-1:0]      m_axis_desc_tag,
  output logic                      m_axis_desc_valid,
  input  logic                      m_axis_desc_ready,
  input  logic [TAG_WIDTH-1:0]      s_axis_desc_status_tag,
  input  logic                      s_axis_desc_status_valid,
  output logic [TAG_WIDTH-1:0]      m_axis_req_status_tag,
  output logic                      m_axis_req_status_valid,
  output logic                      status_error,
  input  logic                      enable
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int XW = (AXI_ADDR_WIDTH > LEN_WIDTH) ? AXI_ADDR_WIDTH : LEN_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t r_state, w_next;

  logic [AXI_ADDR_WIDTH-1:0] r_raddr, r_waddr;
  logic [LEN_WIDTH-1:0]      r_rem;
  logic [TAG_WIDTH-1:0]      r_tag, r_seq;
  logic [OW-1:0]             r_outs, w_outs_nxt;
  logic [XW-1:0]             w_off;
  logic [LEN_WIDTH-1:0]      w_room, w_chunk;
  logic                      w_req_hs, w_desc_hs, w_stat_dec;

  // Room left before the next SEG_SIZE boundary in the write address space.
  assign w_off   = XW'(r_waddr) & XW'(SEG_SIZE - 1);
  assign w_room  = LEN_WIDTH'(SEG_SIZE) - LEN_WIDTH'(w_off);
  assign w_chunk = (r_rem < w_room) ? r_rem : w_room;

  assign s_axis_req_ready  = (r_state == S_IDLE) && enable;
  assign m_axis_desc_valid = (r_state == S_ISSUE) && (r_outs < OW'(MAX_OUTSTANDING));
  assign w_req_hs   = s_axis_req_valid && s_axis_req_ready;
  assign w_desc_hs  = m_axis_desc_valid && m_axis_desc_ready;
  assign w_stat_dec = s_axis_desc_status_valid && (r_outs != '0);
  assign w_outs_nxt = r_outs + OW'(w_desc_hs) - OW'(w_stat_dec);

  assign m_axis_desc_read_addr   = r_raddr;
  assign m_axis_desc_write_addr  = r_waddr;
  assign m_axis_desc_len         = w_chunk;
  assign m_axis_desc_tag         = r_seq;
  assign m_axis_req_status_tag   = r_tag;
  assign m_axis_req_status_valid = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_hs) w_next = (s_axis_req_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_desc_hs && (r_rem == w_chunk)) w_next = S_WAIT;
      S_WAIT:  if (w_outs_nxt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr <= '0;
      r_waddr <= '0;
      r_rem   <= '0;
      r_tag   <= '0;
      r_seq   <= '0;
      r_outs  <= '0;
    end else begin
      r_outs <= w_outs_nxt;
      if (w_req_hs) begin
        r_raddr <= s_axis_req_read_addr;
        r_waddr <= s_axis_req_write_addr;
        r_rem   <= s_axis_req_len;
        r_tag   <= s_axis_req_tag;
      end
      if (w_desc_hs) begin
        r_raddr <= r_raddr + AXI_ADDR_WIDTH'(w_chunk);
        r_waddr <= r_waddr + AXI_ADDR_WIDTH'(w_chunk);
        r_rem   <= r_rem - w_chunk;
        r_seq   <= r_seq + 1'b1;
      end
    end
  end

`ifdef CDMA_SPLIT_ORDER_CHECK_EN
  logic [TAG_WIDTH-1:0] r_exp_tag;
  logic                 r_err;

  // Statuses must come back in issue order; a status with nothing in flight is also an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp_tag <= '0;
      r_err     <= 1'b0;
    end else if (s_axis_desc_status_valid) begin
      r_exp_tag <= r_exp_tag + 1'b1;
      if ((s_axis_desc_status_tag != r_exp_tag) || (r_outs == '0)) r_err <= 1'b1;
    end
  end
  assign status_error = r_err;
`else
  logic w_unused_status_tag;
  assign w_unused_status_tag = ^s_axis_desc_status_tag;
  assign status_error = 1'b0;
`endif
endmodule
